// File: rtl/prno_gen_if.sv
// prno_gen_if: groups the LFSR seed inputs and the registered code outputs of prno_gen.
// The master drives the seeds; the slave (prno_gen) returns P, first and last.
interface prno_gen_if;
  logic [0:9]    R0_in;
  logic [0:9]    R1_in;
  logic [0:1799] P;
  logic [0:23]   first;
  logic [0:23]   last;

  modport master (
    output R0_in,
    output R1_in,
    input  P,
    input  first,
    input  last
  );

  modport slave (
    input  R0_in,
    input  R1_in,
    output P,
    output first,
    output last
  );
endinterface

// File: rtl/prno_gen.sv
// prno_gen: registered 1800-chip code from two 10-stage Fibonacci LFSRs, one new code per cycle.
// Define PRNO_FIRST_LAST_EN to register the first/last 24-chip copies; otherwise both read zero.
module prno_gen (
  input  logic       clk,
  input  logic       rst_n,
  prno_gen_if.slave  bus
);

  localparam int unsigned NumChips = 1800;
  localparam int unsigned EdgeLen  = 24;

  // Fully unrolled: every chip is a pure function of the sampled seeds.
  function automatic logic [0:NumChips-1] gen_code(input logic [0:9] r0_init,
                                                   input logic [0:9] r1_init);
    logic [0:9]          s0;
    logic [0:9]          s1;
    logic                f0;
    logic                f1;
    logic [0:NumChips-1] code;
    s0   = r0_init;
    s1   = r1_init;
    code = '0;
    for (int unsigned n = 0; n < NumChips; n++) begin
      code[n] = s0[9] ^ s1[9];
      f0      = s0[2] ^ s0[9];
      f1      = s1[1] ^ s1[2] ^ s1[5] ^ s1[7] ^ s1[8] ^ s1[9];
      s0      = {f0, s0[0:8]};
      s1      = {f1, s1[0:8]};
    end
    return code;
  endfunction

  logic [0:NumChips-1] w_code;
  logic [0:NumChips-1] r_p;

  assign w_code = gen_code(bus.R0_in, bus.R1_in);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p <= '0;
    end else begin
      r_p <= w_code;
    end
  end

  assign bus.P = r_p;

`ifdef PRNO_FIRST_LAST_EN
  logic [0:EdgeLen-1] r_first;
  logic [0:EdgeLen-1] r_last;

  // Taken from the same combinational code as P so the copies can never skew.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_first <= '0;
      r_last  <= '0;
    end else begin
      r_first <= w_code[0:EdgeLen-1];
      r_last  <= w_code[NumChips-EdgeLen:NumChips-1];
    end
  end

  assign bus.first = r_first;
  assign bus.last  = r_last;
`else
  assign bus.first = '0;
  assign bus.last  = '0;
`endif

endmodule

// File: tb/tb_prno_gen.sv
// tb_prno_gen: directed checks of prno_gen against hand-computed constants and a
// recurrence-based sequence model (a[n+10] form rather than a shift register).
module tb_prno_gen;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  prno_gen_if bus ();

  prno_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Output sequences via linear recurrences: a[n+10] = a[n]^a[n+7] (x^10+x^3+1),
  // b[n+10] = b[n]^b[n+1]^b[n+2]^b[n+4]^b[n+7]^b[n+8]; seeds give a[k] = R[9-k].
  function automatic logic [0:1799] golden(input logic [0:9] r0, input logic [0:9] r1);
    logic          a [0:1809];
    logic          b [0:1809];
    logic [0:1799] code;
    for (int k = 0; k < 10; k++) begin
      a[k] = r0[9-k];
      b[k] = r1[9-k];
    end
    for (int n = 0; n < 1800; n++) begin
      a[n+10] = a[n] ^ a[n+7];
      b[n+10] = b[n] ^ b[n+1] ^ b[n+2] ^ b[n+4] ^ b[n+7] ^ b[n+8];
      code[n] = a[n] ^ b[n];
    end
    return code;
  endfunction

  task automatic check_code(input string tag, input logic [0:1799] exp);
    logic [0:1799] p;
    int            diff;
    p    = bus.P;
    diff = 0;
    for (int i = 0; i < 1800; i++) begin
      if (p[i] !== exp[i]) diff++;
    end
    check_val({tag, "_head"}, 64'(p[0:63]), 64'(exp[0:63]));
    check_val({tag, "_tail"}, 64'(p[1736:1799]), 64'(exp[1736:1799]));
    check_val({tag, "_ndiff"}, 64'(diff), 64'd0);
`ifdef PRNO_FIRST_LAST_EN
    check_val({tag, "_first"}, 64'(bus.first), 64'(exp[0:23]));
    check_val({tag, "_last"}, 64'(bus.last), 64'(exp[1776:1799]));
`else
    check_val({tag, "_first"}, 64'(bus.first), 64'd0);
    check_val({tag, "_last"}, 64'(bus.last), 64'd0);
`endif
  endtask

  logic [0:1799] exp_prev;
  logic [0:9]    r0_v;
  logic [0:9]    r1_v;

  initial begin
    // Reset held for two edges with non-zero inputs present.
    rst_n     = 1'b0;
    bus.R0_in = 10'h2AB;
    bus.R1_in = 10'h155;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_code("reset", '0);

    // All-zero seeds.
    rst_n     = 1'b1;
    bus.R0_in = '0;
    bus.R1_in = '0;
    @(negedge clk);
    check_val("zero_any", 64'(|bus.P), 64'd0);
    check_code("zero", golden(10'b0, 10'b0));

    // R0 all ones, R1 zero: chips follow the R0 sequence alone.
    bus.R0_in = 10'b1111111111;
    bus.R1_in = '0;
    @(negedge clk);
    check_val("ones_p0_10", 64'(bus.P[0:10]), 64'(11'b11111111110));
    check_val("ones_p0_23", 64'(bus.P[0:23]), 64'h00FFC713);
    check_code("ones", golden(10'b1111111111, 10'b0));

    // Identical seeds cancel over the first ten chips.
    bus.R0_in = 10'b0110111011;
    bus.R1_in = 10'b0110111011;
    @(negedge clk);
    check_val("same_p0_9", 64'(bus.P[0:9]), 64'd0);
    check_code("same", golden(10'b0110111011, 10'b0110111011));

    // 64 distinct pairs on consecutive edges, each checked one edge later.
    for (int i = 0; i <= 64; i++) begin
      if (i > 0) check_code($sformatf("b2b%0d", i - 1), exp_prev);
      if (i < 64) begin
        r0_v      = 10'((i * 37 + 5) % 1024);
        r1_v      = 10'((i * 91 + 3) % 1024);
        bus.R0_in = r0_v;
        bus.R1_in = r1_v;
        exp_prev  = golden(r0_v, r1_v);
      end
      @(negedge clk);
    end

    // Reset mid-stream discards the code, then the next edge recovers at once.
    bus.R0_in = 10'h3C5;
    bus.R1_in = 10'h0A7;
    rst_n     = 1'b0;
    @(negedge clk);
    check_code("midreset", '0);
    rst_n     = 1'b1;
    bus.R0_in = 10'h1F0;
    bus.R1_in = 10'h2E9;
    @(negedge clk);
    check_code("postreset", golden(10'h1F0, 10'h2E9));

    // Outputs hold while inputs are unchanged.
    @(negedge clk);
    check_code("hold", golden(10'h1F0, 10'h2E9));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prno_gen.md
PRNO_GEN -- requirements
Module: prno

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port R0_in, input, [0:9]: initial state of register R0; index 0 = stage 1, index 9 = stage 10.
REQ-004 SHALL have port R1_in, input, [0:9]: initial state of register R1, same indexing as R0_in.
REQ-005 SHALL have port P, output, [0:1799]: registered 1800-chip code; P[0] = first chip.
REQ-006 SHALL have port first, output, [0:23]: registered copy of P[0:23].
REQ-007 SHALL have port last, output, [0:23]: registered copy of P[1776:1799].

Function
REQ-008 SHALL sample R0_in and R1_in at every rising clk edge with rst_n=1, and load P/first/last from those values at the same edge (1-cycle latency, no handshake).
REQ-009 SHALL hold outputs stable between edges; a new input pair every cycle yields a new code every cycle (full throughput).
REQ-010 SHALL model R0 as a 10-stage Fibonacci LFSR, polynomial x^10+x^3+1: feedback f0 = R0[2] XOR R0[9].
REQ-011 SHALL model R1 as a 10-stage Fibonacci LFSR, polynomial x^10+x^9+x^8+x^6+x^3+x^2+1: feedback f1 = R1[1]^R1[2]^R1[5]^R1[7]^R1[8]^R1[9].
REQ-012 SHALL compute chip n (n=0..1799) as R0[9] XOR R1[9] of the state before step n; each step shifts index k into k+1 (k=0..8) and loads the feedback into index 0.
REQ-013 SHALL compute all 1800 chips combinationally from the sampled inputs (unrolled loop); no multi-cycle iteration.
REQ-014 SHALL accept any input value, including all-zero; an all-zero register stays zero and contributes 0 to every chip.
REQ-015 SHALL define first[k] = P[k] and last[k] = P[1776+k] for k=0..23, from the same code.

Reset
REQ-016 SHALL clear P, first and last to all zeros on a rising edge with rst_n=0; inputs ignored that cycle.
REQ-017 SHALL produce, on the first edge after rst_n returns to 1, the code for the inputs sampled at that edge.
REQ-018 SHALL discard any in-progress result when rst_n is asserted in any cycle.

Configuration
REQ-019 SHALL, with macro PRNO_FIRST_LAST_EN defined, implement first and last per REQ-006/007/015.
REQ-020 SHALL, with PRNO_FIRST_LAST_EN undefined, keep the first and last ports and tie them to constant zero, with no registers for them; P unaffected.

Verification
REQ-021 Reset: rst_n=0 for 2 edges with arbitrary inputs -> P=0, first=0, last=0.
REQ-022 R0_in=R1_in=10'b0000000000 -> one edge later P all zeros, first=last=24'h000000.
REQ-023 R0_in=10'b1111111111, R1_in=0 -> P[0:9]=10'b1111111111, P[10]=0; first = R0 LFSR sequence only.
REQ-024 R0_in=R1_in=any X (e.g., 10'b0110111011) -> P[0:9] all zero; later chips follow REQ-012.
REQ-025 Back-to-back: 64 distinct input pairs on consecutive edges -> each output matches a golden LFSR model of the pair sampled one edge earlier; no bubbles.
REQ-026 With PRNO_FIRST_LAST_EN defined, for each test pair -> first==P[0:23], last==P[1776:1799]; undefined -> first=last=0.
